// File: rtl/seq_div_32bit_pkg.sv
// Shared ALU definitions: opcodes, divider FSM states, iteration count.
// Imported by the divider top and its helpers.
package seq_div_32bit_pkg;

    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_MUL  = 4'h8;
    localparam logic [3:0] ALU_MULU = 4'h9;
    localparam logic [3:0] ALU_DIV  = 4'hA;
    localparam logic [3:0] ALU_DIVU = 4'hB;

    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

endpackage

// File: rtl/seq_div_32bit_negate.sv
// Two's-complement negate: 32-bit bitwise inverter followed by +1.
// Used for operand magnitudes and for result sign fix.
module negate_32bit (
    input  logic [31:0] a,
    output logic [31:0] y
);

    logic [31:0] inv;

    assign inv = ~a;
    assign y   = inv + 32'd1;

endmodule

// File: rtl/seq_div_32bit.sv
// Sequential restoring divider, signed/unsigned, fixed 35-cycle latency.
// Operands are converted to magnitudes, divided, then sign-fixed.
module seq_div_32bit
    import seq_div_32bit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    div_state_t  state;
    logic [5:0]  cnt;
    logic        a_neg;
    logic        b_neg;
    logic        zero_q;
    logic [31:0] a_raw;
    logic [31:0] b_mag;
    logic [31:0] qr;
    logic [31:0] rr;
    logic [31:0] q_fix;
    logic [31:0] r_fix;

    logic [31:0] a_inv_in;
    logic [31:0] b_inv_in;
    logic [31:0] a_mag_in;
    logic [31:0] b_mag_in;
    logic [31:0] q_neg;
    logic [31:0] r_neg;
    logic [32:0] shifted;
    logic [32:0] diff;

    negate_32bit u_neg_a (.a(dividend), .y(a_inv_in));
    negate_32bit u_neg_b (.a(divisor),  .y(b_inv_in));
    negate_32bit u_neg_q (.a(qr),       .y(q_neg));
    negate_32bit u_neg_r (.a(rr),       .y(r_neg));

    assign a_mag_in = (is_signed && dividend[31]) ? a_inv_in : dividend;
    assign b_mag_in = (is_signed && divisor[31])  ? b_inv_in : divisor;

    // One restoring step: shift in next dividend bit, subtract via add of ~d + 1.
    assign shifted = {rr, qr[31]};
    assign diff    = shifted + {1'b1, ~b_mag} + 33'd1;

    // Divider FSM, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            zero_q    <= 1'b0;
            a_raw     <= '0;
            b_mag     <= '0;
            qr        <= '0;
            rr        <= '0;
            q_fix     <= '0;
            r_fix     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    // the cycle showing done is IDLE but must not accept
                    if (start && !done) begin
                        a_raw  <= dividend;
                        a_neg  <= is_signed && dividend[31];
                        b_neg  <= is_signed && divisor[31];
                        zero_q <= (divisor == '0);
                        qr     <= a_mag_in;
                        b_mag  <= b_mag_in;
                        rr     <= '0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        state  <= S_DIV;
                    end
                end
                S_DIV: begin
                    rr  <= diff[32] ? shifted[31:0] : diff[31:0];
                    qr  <= {qr[30:0], ~diff[32]};
                    cnt <= cnt + 6'd1;
                    if (cnt == 6'(DIV_ITERS - 1)) begin
                        state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (zero_q) begin
                        q_fix <= '1;
                        r_fix <= a_raw;
                    end else begin
                        q_fix <= (a_neg ^ b_neg) ? q_neg : qr;
                        r_fix <= a_neg ? r_neg : rr;
                    end
                    state <= S_DONE;
                end
                S_DONE: begin
                    quotient  <= q_fix;
                    remainder <= r_fix;
                    div_zero  <= zero_q;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_div_32bit.sv
// Scoreboard bench for seq_div_32bit: directed corner cases plus random ops.
// Expected results come from plain 64-bit arithmetic.
module tb_seq_div_32bit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;

    seq_div_32bit #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic s);
        exp_t   e;
        longint la;
        longint lb;
        longint lq;
        longint lr;
        e.due = 0;
        if (b == 32'd0) begin
            e.q = 32'hFFFF_FFFF;
            e.r = a;
            e.z = 1'b1;
        end else begin
            if (s) begin
                la = longint'($signed(a));
                lb = longint'($signed(b));
            end else begin
                la = longint'({32'd0, a});
                lb = longint'({32'd0, b});
            end
            lq  = la / lb;
            lr  = la % lb;
            e.q = lq[31:0];
            e.r = lr[31:0];
            e.z = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] want);
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, want);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL spurious_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                chk("quotient", quotient, e.q);
                chk("remainder", remainder, e.r);
                chk("div_zero", {31'd0, div_zero}, {31'd0, e.z});
                chk("latency", cyc, e.due);
                chk("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Drives one start pulse; push=1 when the request will be accepted.
    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic s, input bit push);
        exp_t e;
        @(negedge clk);
        e     = model(a, b, s);
        e.due = cyc + 35;
        if (push) begin
            sb.push_back(e);
            n_vec++;
        end
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int k;
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_err++;
            $display("FAIL timeout: got no done after %0d cycles expected done", k);
        end
    endtask

    task automatic run(input logic [31:0] a, input logic [31:0] b,
                       input logic s);
        issue(a, b, s, 1'b1);
        wait_done();
        @(negedge clk);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        chk("rst_z", {31'd0, div_zero}, 32'd0);
        reset = 1'b0;

        run(32'd100, 32'd7, 1'b0);
        run(32'hFFFF_FFF9, 32'd2, 1'b1);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run(32'hFFFF_FFFF, 32'd1, 1'b0);
        run(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run(32'd12345, 32'd0, 1'b0);

        // results hold after done
        repeat (3) @(negedge clk);
        chk("hold_q", quotient, 32'hFFFF_FFFF);
        chk("hold_r", remainder, 32'd12345);
        chk("hold_z", {31'd0, div_zero}, 32'd1);

        run(32'hFFFF_CFC7, 32'd0, 1'b1);

        // start while busy is ignored
        issue(32'd50, 32'd5, 1'b0, 1'b1);
        repeat (9) @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
        @(posedge clk);
        #1 start = 1'b0;
        chk("busy_mid", {31'd0, busy}, 32'd1);
        wait_done();

        // start in the done cycle is ignored
        start    = 1'b1;
        dividend = 32'd1;
        divisor  = 32'd1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("busy_after_done_start", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);

        // reset aborts an operation in flight
        issue(32'd1000, 32'd3, 1'b0, 1'b1);
        repeat (19) @(negedge clk);
        reset = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_q", quotient, 32'd0);
        chk("abort_r", remainder, 32'd0);
        chk("abort_z", {31'd0, div_zero}, 32'd0);
        repeat (40) @(negedge clk);
        run(32'd9, 32'd3, 1'b0);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic        s;
            a = $urandom;
            b = $urandom;
            s = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 17));
                2: b = b >> $urandom_range(8, 28);
                3: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                default: ;
            endcase
            run(a, b, s);
        end

        repeat (5) @(negedge clk);
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_div_32bit.md
SEQ_DIV_32BIT -- requirements
Module: seq_div_32bit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/result width; only 32 is supported.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 The block SHALL have port is_signed  input  1  1 = two's-complement divide (div), 0 = unsigned (divu); captured with start.
REQ-006 The block SHALL have port dividend  input  32  numerator; captured with start.
REQ-007 The block SHALL have port divisor  input  32  denominator; captured with start.
REQ-008 The block SHALL have port busy  output  1  high from the cycle after accepted start until done.
REQ-009 The block SHALL have port done  output  1  one-cycle pulse; quotient/remainder valid.
REQ-010 The block SHALL have port quotient  output  32  result destined for LO.
REQ-011 The block SHALL have port remainder  output  32  result destined for HI.
REQ-012 The block SHALL have port div_zero  output  1  divisor was zero for the last completed operation.

Function
REQ-013 The FSM SHALL have states IDLE, DIV, FIX, DONE.
REQ-014 In IDLE with start=1, the block SHALL capture operands and is_signed, load operand magnitudes, clear the 6-bit iteration counter, and go to DIV.
REQ-015 In DIV, the block SHALL perform one restoring shift-subtract step per cycle for exactly 32 cycles, then go to FIX.
REQ-016 Subtraction SHALL be performed as add of the bitwise-inverted divisor magnitude plus carry-in 1, using a 33-bit partial remainder.
REQ-017 In FIX, the block SHALL apply signs.
  - Quotient: negated if is_signed and operand signs differ.
  - Remainder: negated if is_signed and dividend negative.
  - Then go to DONE.
REQ-018 In DONE, the block SHALL assert done for exactly one cycle, register the outputs, and return to IDLE.
REQ-019 Latency SHALL be fixed: start sampled at edge 0 -> done high in the cycle after edge 34, for all operands, including divide-by-zero.
REQ-020 Divisor=0 SHALL produce quotient=0xFFFFFFFF and remainder=dividend (raw, no sign fix), with div_zero=1.
REQ-021 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient=0x80000000 and remainder=0, with no flag raised.
REQ-022 start while busy SHALL be ignored; the operation in flight is unaffected.
REQ-023 quotient, remainder and div_zero SHALL hold their values from done until the next done.
REQ-024 start asserted in the same cycle as done SHALL be ignored; start is accepted only in IDLE.

Reset
REQ-025 When reset=1 at a clock edge, the block SHALL go to IDLE with busy=0, done=0, quotient=0, remainder=0, div_zero=0, and the counter and internal registers cleared.
REQ-026 Reset SHALL take priority over start and SHALL abort any operation in flight with no done pulse.

Structure
REQ-027 FSM state encodings and the iteration count constant (32) SHALL live in the shared ALU definitions header/package, alongside the ALU opcode constants.
REQ-028 One sub-module negate_32bit SHALL be used: the team's 32-bit bitwise inverter plus a +1 increment, instantiated for operand magnitude and result sign fix.
REQ-029 The datapath SHALL be structural where the existing 1-bit/32-bit gate library covers it; the FSM and counter are behavioural.

Verification
REQ-030 The bench SHALL cover unsigned 100 / 7: done at cycle 34 after start, with quotient=14, remainder=2, div_zero=0.
REQ-031 The bench SHALL cover signed -7 / 2 (0xFFFFFFF9 / 2): quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-032 The bench SHALL cover signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. Unsigned 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0.
REQ-033 The bench SHALL cover 12345 / 0: at cycle 34, quotient=0xFFFFFFFF, remainder=12345, div_zero=1.
REQ-034 The bench SHALL cover start for 50 / 5, then start pulsed at cycle 10 with 9 / 3: the result is quotient=10, remainder=0, with one done pulse only.
REQ-035 The bench SHALL cover reset asserted at cycle 20 of an operation: the next cycle shows busy=0, outputs 0, and no done pulse. A following 9 / 3 completes with quotient=3, remainder=0.
